// File: rtl/ir_nec_pkg.sv
// Shared definitions for the NEC infrared decoder: FSM states, timing
// windows in microseconds and the width of the microsecond counter.
package ir_nec_pkg;

    localparam int US_W    = 14;
    localparam int NEC_CLK_DIV = 50;

    localparam logic [US_W-1:0] NEC_LEAD_LO_MIN = 14'd8000;
    localparam logic [US_W-1:0] NEC_LEAD_LO_MAX = 14'd10000;
    localparam logic [US_W-1:0] NEC_LEAD_HI_MIN = 14'd4000;
    localparam logic [US_W-1:0] NEC_LEAD_HI_MAX = 14'd5000;
    localparam logic [US_W-1:0] NEC_RPT_HI_MIN  = 14'd2000;
    localparam logic [US_W-1:0] NEC_RPT_HI_MAX  = 14'd2500;
    localparam logic [US_W-1:0] NEC_BIT_MIN     = 14'd400;
    localparam logic [US_W-1:0] NEC_BIT_MAX     = 14'd700;
    localparam logic [US_W-1:0] NEC_ONE_MIN     = 14'd1500;
    localparam logic [US_W-1:0] NEC_ONE_MAX     = 14'd1900;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEAD_LO = 3'd1,
        LEAD_HI = 3'd2,
        BIT_LO  = 3'd3,
        BIT_HI  = 3'd4,
        TAIL    = 3'd5
    } nec_state_t;

    // Inclusive window test on a measured width.
    function automatic logic in_win(input logic [US_W-1:0] w,
                                    input logic [US_W-1:0] lo,
                                    input logic [US_W-1:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Synchronizes the raw IR pin, detects edges and measures the time since
// the last edge in microseconds (saturating).
module ir_pulse_timer
    import ir_nec_pkg::*;
#(
    parameter int CLK_DIV = NEC_CLK_DIV
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            irda_rx,
    output logic            rx_sync,
    output logic            fall,
    output logic            rise,
    output logic [US_W-1:0] width_us
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic          sync1, sync2, sync3;
    logic [PW-1:0] presc;
    logic          tick;

    // Two-flop synchronizer plus one delay flop for edge detection; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= irda_rx;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rx_sync = sync2;
    assign fall    = sync3 & ~sync2;
    assign rise    = ~sync3 & sync2;
    assign tick    = (presc == PW'(CLK_DIV - 1));

    // Prescaler and microsecond counter, both restarted by every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            width_us <= '0;
        end else if (fall || rise) begin
            presc    <= '0;
            width_us <= '0;
        end else if (tick) begin
            presc    <= '0;
            if (width_us != '1) width_us <= width_us + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC infrared frame decoder: leader, 32 data bits, key-code checksum and
// repeat codes, with registered strobes toward the display stage.
// Handshake: data_valid, repeat_code and frame_err are single-cycle strobes
// with no ready/backpressure; DATA is stable from data_valid until the next one.
module ir_nec_decoder
    import ir_nec_pkg::*;
#(
    parameter int              CLK_DIV     = NEC_CLK_DIV,
    parameter logic [US_W-1:0] LEAD_LO_MIN = NEC_LEAD_LO_MIN,
    parameter logic [US_W-1:0] LEAD_LO_MAX = NEC_LEAD_LO_MAX,
    parameter logic [US_W-1:0] LEAD_HI_MIN = NEC_LEAD_HI_MIN,
    parameter logic [US_W-1:0] LEAD_HI_MAX = NEC_LEAD_HI_MAX,
    parameter logic [US_W-1:0] RPT_HI_MIN  = NEC_RPT_HI_MIN,
    parameter logic [US_W-1:0] RPT_HI_MAX  = NEC_RPT_HI_MAX,
    parameter logic [US_W-1:0] BIT_MIN     = NEC_BIT_MIN,
    parameter logic [US_W-1:0] BIT_MAX     = NEC_BIT_MAX,
    parameter logic [US_W-1:0] ONE_MIN     = NEC_ONE_MIN,
    parameter logic [US_W-1:0] ONE_MAX     = NEC_ONE_MAX
) (
    input  logic        CLK_50M,
    input  logic        rst_n,
    input  logic        IRDA_RX,
    output logic [31:0] DATA,
    output logic        data_valid,
    output logic        flag_complete,
    output logic        repeat_code,
    output logic        frame_err,
    output logic [2:0]  state_dbg
);

    nec_state_t      state;
    logic            rx_sync, fall, rise;
    logic [US_W-1:0] width_us;
    logic [US_W-1:0] cur_max;
    logic [31:0]     shreg;
    logic [31:0]     word_next;
    logic [4:0]      bit_idx;
    logic            bit_val;
    logic            lead_start;

    ir_pulse_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk      (CLK_50M),
        .rst_n    (rst_n),
        .irda_rx  (IRDA_RX),
        .rx_sync  (rx_sync),
        .fall     (fall),
        .rise     (rise),
        .width_us (width_us)
    );

    assign state_dbg  = state;
    assign lead_start = fall && !rx_sync;

    // Longest width the current state tolerates before timing out.
    always_comb begin
        cur_max   = '1;
        bit_val   = in_win(width_us, ONE_MIN, ONE_MAX);
        word_next = {bit_val, shreg[31:1]};
        case (state)
            LEAD_LO:      cur_max = LEAD_LO_MAX;
            LEAD_HI:      cur_max = LEAD_HI_MAX;
            BIT_LO, TAIL: cur_max = BIT_MAX;
            BIT_HI:       cur_max = ONE_MAX;
            default:      cur_max = '1;
        endcase
    end

    // Frame FSM with shift register, bit index and registered strobes.
    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_idx       <= '0;
            DATA          <= '0;
            data_valid    <= 1'b0;
            flag_complete <= 1'b0;
            repeat_code   <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            repeat_code <= 1'b0;
            frame_err   <= 1'b0;
            if (state != IDLE && width_us > cur_max) begin
                frame_err <= 1'b1;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: if (lead_start) begin
                        state         <= LEAD_LO;
                        flag_complete <= 1'b0;
                    end
                    LEAD_LO: if (rise) begin
                        if (in_win(width_us, LEAD_LO_MIN, LEAD_LO_MAX)) state <= LEAD_HI;
                        else begin frame_err <= 1'b1; state <= IDLE; end
                    end
                    LEAD_HI: if (fall) begin
                        if (in_win(width_us, LEAD_HI_MIN, LEAD_HI_MAX)) begin
                            state   <= BIT_LO;
                            bit_idx <= '0;
                            shreg   <= '0;
                        end else if (in_win(width_us, RPT_HI_MIN, RPT_HI_MAX)) begin
                            repeat_code <= 1'b1;
                            state       <= TAIL;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    BIT_LO: if (rise) begin
                        if (in_win(width_us, BIT_MIN, BIT_MAX)) state <= BIT_HI;
                        else begin frame_err <= 1'b1; state <= IDLE; end
                    end
                    BIT_HI: if (fall) begin
                        if (in_win(width_us, BIT_MIN, BIT_MAX) || bit_val) begin
                            shreg <= word_next;
                            if (bit_idx != 5'd31) begin
                                bit_idx <= bit_idx + 1'b1;
                                state   <= BIT_LO;
                            end else if (word_next[31:24] == ~word_next[23:16]) begin
                                DATA          <= word_next;
                                data_valid    <= 1'b1;
                                flag_complete <= 1'b1;
                                state         <= TAIL;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= IDLE;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    TAIL: if (rise) begin
                        if (in_win(width_us, BIT_MIN, BIT_MAX)) state <= IDLE;
                        else begin frame_err <= 1'b1; state <= IDLE; end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed bench for ir_nec_decoder. Timing windows are scaled down by 20
// and the tick divider set to 2 so whole frames stay short.
module tb_ir_nec_decoder;

    localparam int CDIV = 2;
    // Nominal scaled pulse widths in microseconds.
    localparam int T_LEAD_LO = 450;
    localparam int T_LEAD_HI = 225;
    localparam int T_RPT_HI  = 112;
    localparam int T_BIT     = 28;
    localparam int T_ONE     = 84;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        irda_rx = 1'b1;
    logic [31:0] data;
    logic        data_valid, flag_complete, repeat_code, frame_err;
    logic [2:0]  state_dbg;

    int checks = 0;
    int failures = 0;
    int dv_cnt = 0, rpt_cnt = 0, err_cnt = 0, overlap_cnt = 0;
    int cyc = 0, err_cyc = 0;

    ir_nec_decoder #(
        .CLK_DIV(CDIV),
        .LEAD_LO_MIN(14'd400), .LEAD_LO_MAX(14'd500),
        .LEAD_HI_MIN(14'd200), .LEAD_HI_MAX(14'd250),
        .RPT_HI_MIN(14'd100),  .RPT_HI_MAX(14'd125),
        .BIT_MIN(14'd20),      .BIT_MAX(14'd35),
        .ONE_MIN(14'd75),      .ONE_MAX(14'd95)
    ) dut (
        .CLK_50M(clk),
        .rst_n(rst_n),
        .IRDA_RX(irda_rx),
        .DATA(data),
        .data_valid(data_valid),
        .flag_complete(flag_complete),
        .repeat_code(repeat_code),
        .frame_err(frame_err),
        .state_dbg(state_dbg)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Strobe monitor sampled away from the active edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (data_valid) dv_cnt = dv_cnt + 1;
        if (repeat_code) rpt_cnt = rpt_cnt + 1;
        if (frame_err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if ((32'(data_valid) + 32'(repeat_code) + 32'(frame_err)) > 1) overlap_cnt = overlap_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver: hold the line at a level for a number of microseconds
    task automatic hold(input logic lvl, input int us);
        irda_rx = lvl;
        repeat (us * CDIV) @(posedge clk);
        #1;
    endtask

    task automatic send_leader();
        hold(1'b0, T_LEAD_LO);
        hold(1'b1, T_LEAD_HI);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b0, T_BIT);
            hold(1'b1, w[i] ? T_ONE : T_BIT);
        end
    endtask

    task automatic send_frame(input logic [31:0] w);
        send_leader();
        send_bits(w, 32);
        hold(1'b0, T_BIT);
        hold(1'b1, 60);
    endtask

    int dv0, err0, rpt0, dt;

    initial begin
        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_data", data, 32'h0);
        check("rst_dv", {31'b0, data_valid}, 32'h0);
        check("rst_flag", {31'b0, flag_complete}, 32'h0);
        check("rst_rpt", {31'b0, repeat_code}, 32'h0);
        check("rst_err", {31'b0, frame_err}, 32'h0);
        check("rst_state", {29'b0, state_dbg}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hold(1'b1, 20);

        // Valid frame 12 34 56 A9
        dv0 = dv_cnt; err0 = err_cnt;
        send_frame(32'hA9563412);
        check("f1_data", data, 32'hA9563412);
        check("f1_dv", dv_cnt - dv0, 1);
        check("f1_flag", {31'b0, flag_complete}, 32'h1);
        check("f1_err", err_cnt - err0, 0);

        // Short noise pulse from idle, then another valid frame
        err0 = err_cnt;
        hold(1'b0, 50);
        hold(1'b1, 60);
        check("noise_err", err_cnt - err0, 1);
        check("noise_flag", {31'b0, flag_complete}, 32'h0);
        check("noise_state", {29'b0, state_dbg}, 32'h0);
        dv0 = dv_cnt; err0 = err_cnt;
        send_frame(32'hBA45FF00);
        check("f2_data", data, 32'hBA45FF00);
        check("f2_dv", dv_cnt - dv0, 1);
        check("f2_err", err_cnt - err0, 0);

        // Bad checksum: last byte A8
        dv0 = dv_cnt; err0 = err_cnt;
        send_frame(32'hA8563412);
        check("cks_err", err_cnt - err0, 1);
        check("cks_dv", dv_cnt - dv0, 0);
        check("cks_data", data, 32'hBA45FF00);
        check("cks_flag", {31'b0, flag_complete}, 32'h0);

        // Repeat code
        dv0 = dv_cnt; err0 = err_cnt; rpt0 = rpt_cnt;
        hold(1'b0, T_LEAD_LO);
        hold(1'b1, T_RPT_HI);
        hold(1'b0, T_BIT);
        hold(1'b1, 60);
        check("rpt_cnt", rpt_cnt - rpt0, 1);
        check("rpt_err", err_cnt - err0, 0);
        check("rpt_dv", dv_cnt - dv0, 0);
        check("rpt_data", data, 32'hBA45FF00);

        // Line held high after bit 10 burst: timeout just past 95 us
        err0 = err_cnt;
        send_leader();
        send_bits(32'hA9563412, 10);
        hold(1'b0, T_BIT);
        irda_rx = 1'b1;
        dv0 = cyc;
        for (int i = 0; i < 400 && err_cnt == err0; i++) @(negedge clk);
        dt = err_cyc - dv0;
        check("tmo_seen", err_cnt - err0, 1);
        check("tmo_early", {31'b0, dt >= 96 * CDIV}, 32'h1);
        check("tmo_late", {31'b0, dt <= 97 * CDIV + 6}, 32'h1);
        @(posedge clk); #1;
        hold(1'b1, 200);
        check("tmo_state", {29'b0, state_dbg}, 32'h0);
        check("tmo_once", err_cnt - err0, 1);
        dv0 = dv_cnt;
        send_frame(32'hA9563412);
        check("f3_data", data, 32'hA9563412);
        check("f3_dv", dv_cnt - dv0, 1);

        // Reset during byte 2, then a full frame
        send_leader();
        send_bits(32'hA9563412, 12);
        irda_rx = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mrst_data", data, 32'h0);
        check("mrst_flag", {31'b0, flag_complete}, 32'h0);
        check("mrst_strb", {29'b0, data_valid, repeat_code, frame_err}, 32'h0);
        check("mrst_state", {29'b0, state_dbg}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hold(1'b1, 20);
        dv0 = dv_cnt; err0 = err_cnt;
        send_frame(32'hA9563412);
        check("f4_data", data, 32'hA9563412);
        check("f4_dv", dv_cnt - dv0, 1);
        check("f4_err", err_cnt - err0, 0);
        check("f4_flag", {31'b0, flag_complete}, 32'h1);

        // Strobes never overlapped anywhere in the run
        check("overlap", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench time limit");
    end

endmodule
